exec_core: RTL and testbench

EXEC_CORE -- requirements
Module: exec_core

---
 rtl/exec_core_if.sv | 36 +++
 rtl/exec_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_exec_core.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_core_if.sv
// Control and data bundle between the execution core and its regfile/memory/IR environment.
// Control strobes are level signals that qualify the bus for the current step only; there is no stall.
interface exec_core_if;
    logic [7:0] opcode;
    logic [7:0] data_in;
    logic [7:0] alu_out;
    logic [7:0] flags_out;
    logic       output_alu;
    logic       alu_out_en;
    logic       alu_flags_out_en;
    logic       reg_out_en;
    logic       reg_write_en;
    logic       mem_out_en;
    logic       mem_write_en;
    logic       mem_mar_write_en;
    logic       ir_write_en;
    logic       hlt;
    logic [1:0] reg_ext_op;
    logic [4:0] reg_write_sel;
    logic [4:0] reg_read_sel;
    logic [2:0] step;

    modport master (
        input  opcode, data_in,
        output alu_out, flags_out, output_alu, alu_out_en, alu_flags_out_en,
               reg_out_en, reg_write_en, mem_out_en, mem_write_en, mem_mar_write_en,
               ir_write_en, hlt, reg_ext_op, reg_write_sel, reg_read_sel, step
    );

    modport slave (
        output opcode, data_in,
        input  alu_out, flags_out, output_alu, alu_out_en, alu_flags_out_en,
               reg_out_en, reg_write_en, mem_out_en, mem_write_en, mem_mar_write_en,
               ir_write_en, hlt, reg_ext_op, reg_write_sel, reg_read_sel, step
    );
endinterface

// File: rtl/exec_core.sv
// 8080-style execution core: accumulator ALU plus a step-counter controller that sequences
// fetch and a small instruction subset; the step counter is visible on bus.step.
module exec_core #(
    parameter int PC_SEL = 13,
    parameter int WZ_SEL = 11,
    parameter int W_SEL  = 6,
    parameter int Z_SEL  = 7
) (
    input  logic         clk,
    input  logic         rst,
    output logic         clk_out,
    exec_core_if.master  bus
);
    localparam logic [4:0] SEL_PC   = 5'(PC_SEL);
    localparam logic [4:0] SEL_WZ   = 5'(WZ_SEL);
    localparam logic [4:0] SEL_W    = 5'(W_SEL);
    localparam logic [4:0] SEL_Z    = 5'(Z_SEL);
    localparam logic [1:0] EXT_INC  = 2'b01;
    localparam logic [1:0] EXT_INC2 = 2'b11;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_PASS = 5'd8;

    logic [2:0] step, step_nx;
    logic       hlt_r, hlt_nx;
    logic [7:0] acc, tmp, act, flags;

    logic [4:0] alu_opcode;
    logic       ctrl_sig, flags_from_bus;
    logic       acc_we, tmp_we, flags_we, act_store, act_restore;
    logic       last, hlt_c;

    logic [7:0] res, b_eff, flags_c;
    logic [8:0] sum9;
    logic [4:0] sum5;
    logic       c_eff, arith, sub, ac_c, cy_c;

    logic       zf, is_mvi, is_adi, is_out, is_mov, is_alu, is_jmp, jmp_skip;
    logic [4:0] r_sel;

    assign zf       = flags[6];
    assign r_sel    = {2'b00, bus.opcode[2:0]};
    assign is_mvi   = (bus.opcode == 8'h3E);
    assign is_adi   = (bus.opcode == 8'hC6);
    assign is_out   = (bus.opcode == 8'hD3);
    assign is_mov   = (bus.opcode[7:3] == 5'b01111) && (bus.opcode[2:0] < 3'd6);
    assign is_alu   = (bus.opcode[7:6] == 2'b10) && (bus.opcode[2:0] < 3'd6);
    assign is_jmp   = (bus.opcode == 8'hC3) || (bus.opcode == 8'hCA && zf) || (bus.opcode == 8'hC2 && !zf);
    assign jmp_skip = (bus.opcode == 8'hCA && !zf) || (bus.opcode == 8'hC2 && zf);

    // ---- step / halt register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            step  <= 3'd0;
            hlt_r <= 1'b0;
        end else begin
            step  <= step_nx;
            hlt_r <= hlt_nx;
        end
    end

    // ---- next step ----
    always_comb begin
        step_nx = step;
        hlt_nx  = hlt_r | hlt_c;
        if (!hlt_c) step_nx = last ? 3'd0 : step + 3'd1;
    end

    // ---- control outputs ----
    always_comb begin
        bus.output_alu       = 1'b0;
        bus.alu_out_en       = 1'b0;
        bus.alu_flags_out_en = 1'b0;
        bus.reg_out_en       = 1'b0;
        bus.reg_write_en     = 1'b0;
        bus.mem_out_en       = 1'b0;
        bus.mem_write_en     = 1'b0;
        bus.mem_mar_write_en = 1'b0;
        bus.ir_write_en      = 1'b0;
        bus.reg_ext_op       = 2'b00;
        bus.reg_write_sel    = 5'd0;
        bus.reg_read_sel     = 5'd0;
        alu_opcode           = ALU_PASS;
        ctrl_sig             = 1'b0;
        flags_from_bus       = 1'b0;
        acc_we               = 1'b0;
        tmp_we               = 1'b0;
        flags_we             = 1'b0;
        act_store            = 1'b0;
        act_restore          = 1'b0;
        last                 = 1'b0;
        hlt_c                = 1'b0;
        if (hlt_r) begin
            hlt_c = 1'b1;
        end else begin
            case (step)
                3'd0: begin
                    bus.reg_read_sel     = SEL_PC;
                    bus.reg_out_en       = 1'b1;
                    bus.mem_mar_write_en = 1'b1;
                end
                3'd1: begin
                    bus.mem_out_en    = 1'b1;
                    bus.ir_write_en   = 1'b1;
                    bus.reg_write_sel = SEL_PC;
                    bus.reg_ext_op    = EXT_INC;
                end
                3'd2: begin
                    if (bus.opcode == 8'h76) begin
                        hlt_c = 1'b1;
                    end else if (is_mvi || is_adi || is_jmp) begin
                        bus.reg_read_sel     = SEL_PC;
                        bus.reg_out_en       = 1'b1;
                        bus.mem_mar_write_en = 1'b1;
                        // One write select: a jump advances PC while its value is latched into MAR.
                        if (is_jmp) begin
                            bus.reg_write_sel = SEL_PC;
                            bus.reg_ext_op    = EXT_INC;
                        end
                    end else if (is_mov) begin
                        bus.reg_read_sel = r_sel;
                        bus.reg_out_en   = 1'b1;
                        acc_we           = 1'b1;
                        last             = 1'b1;
                    end else if (is_alu) begin
                        bus.reg_read_sel = r_sel;
                        bus.reg_out_en   = 1'b1;
                        tmp_we           = 1'b1;
                    end else if (is_out) begin
                        alu_opcode        = ALU_PASS;
                        bus.output_alu    = 1'b1;
                        bus.reg_write_sel = SEL_PC;
                        bus.reg_ext_op    = EXT_INC;
                        last              = 1'b1;
                    end else if (jmp_skip) begin
                        bus.reg_write_sel = SEL_PC;
                        bus.reg_ext_op    = EXT_INC2;
                        last              = 1'b1;
                    end else begin
                        last = 1'b1;
                    end
                end
                3'd3: begin
                    if (is_mvi || is_adi) begin
                        bus.mem_out_en    = 1'b1;
                        bus.reg_write_sel = SEL_PC;
                        bus.reg_ext_op    = EXT_INC;
                        acc_we            = is_mvi;
                        tmp_we            = is_adi;
                        last              = is_mvi;
                    end else if (is_alu) begin
                        alu_opcode = {2'b00, bus.opcode[5:3]};
                        flags_we   = 1'b1;
                        acc_we     = (bus.opcode[5:3] != 3'd7);
                        ctrl_sig   = 1'b1;
                        last       = 1'b1;
                    end else if (is_jmp) begin
                        bus.mem_out_en    = 1'b1;
                        bus.reg_write_en  = 1'b1;
                        bus.reg_write_sel = SEL_Z;
                    end else begin
                        last = 1'b1;
                    end
                end
                3'd4: begin
                    if (is_adi) begin
                        alu_opcode = ALU_ADD;
                        flags_we   = 1'b1;
                        acc_we     = 1'b1;
                        ctrl_sig   = 1'b1;
                        last       = 1'b1;
                    end else if (is_jmp) begin
                        bus.reg_read_sel     = SEL_PC;
                        bus.reg_out_en       = 1'b1;
                        bus.mem_mar_write_en = 1'b1;
                        bus.reg_write_sel    = SEL_PC;
                        bus.reg_ext_op       = EXT_INC;
                    end else begin
                        last = 1'b1;
                    end
                end
                3'd5: begin
                    if (is_jmp) begin
                        bus.mem_out_en    = 1'b1;
                        bus.reg_write_en  = 1'b1;
                        bus.reg_write_sel = SEL_W;
                    end else begin
                        last = 1'b1;
                    end
                end
                3'd6: begin
                    if (is_jmp) begin
                        bus.reg_read_sel  = SEL_WZ;
                        bus.reg_out_en    = 1'b1;
                        bus.reg_write_en  = 1'b1;
                        bus.reg_write_sel = SEL_PC;
                    end
                    last = 1'b1;
                end
                default: last = 1'b1;
            endcase
        end
    end

    // ---- ALU ----
    always_comb begin
        arith = 1'b0;
        sub   = 1'b0;
        b_eff = tmp;
        c_eff = 1'b0;
        res   = acc;
        case (alu_opcode)
            5'd0: arith = 1'b1;
            5'd1: begin arith = 1'b1; c_eff = flags[0]; end
            // Subtraction is a + ~b + ~borrow; AC is the nibble carry of that sum, CY its inverted carry.
            5'd2, 5'd7: begin arith = 1'b1; sub = 1'b1; b_eff = ~tmp; c_eff = 1'b1; end
            5'd3: begin arith = 1'b1; sub = 1'b1; b_eff = ~tmp; c_eff = ~flags[0]; end
            5'd4: res = acc & tmp;
            5'd5: res = acc ^ tmp;
            5'd6: res = acc | tmp;
            default: res = acc;
        endcase
        sum9 = {1'b0, acc} + {1'b0, b_eff} + {8'b0, c_eff};
        sum5 = {1'b0, acc[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, c_eff};
        ac_c = 1'b0;
        cy_c = 1'b0;
        if (arith) begin
            res  = sum9[7:0];
            ac_c = sum5[4];
            cy_c = sub ? ~sum9[8] : sum9[8];
        end
        flags_c = {res[7], (res == 8'h00), 1'b0, ac_c, 1'b0, ~^res, 1'b1, cy_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= 8'h00;
            tmp   <= 8'h00;
            act   <= 8'h00;
            flags <= 8'h00;
        end else begin
            if (act_restore)  acc <= act;
            else if (acc_we)  acc <= ctrl_sig ? res : bus.data_in;
            if (tmp_we)       tmp <= bus.data_in;
            if (flags_we)     flags <= flags_from_bus ? bus.data_in : flags_c;
            if (act_store)    act <= acc;
        end
    end

    assign bus.alu_out   = res;
    assign bus.flags_out = flags;
    assign bus.hlt       = hlt_c;
    assign bus.step      = step;
    assign clk_out       = clk & ~hlt_c;
endmodule

// File: tb/tb_exec_core.sv
// Bench for exec_core: a small regfile/memory environment around the core and an
// instruction-level model that predicts acc, flags, PC and cycle count per instruction.
module tb_exec_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_out;
    exec_core_if bus_if ();

    exec_core dut (.clk(clk), .rst(rst), .clk_out(clk_out), .bus(bus_if.master));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gp_init(input int i);
        case (i)
            0: return 8'h80;  // B
            1: return 8'h06;  // C
            2: return 8'h3C;  // D
            3: return 8'h04;  // E
            default: return 8'h00;
        endcase
    endfunction

    // ---- environment: regfile, memory, IR, bus ----
    logic [7:0]  mem [256];
    logic [7:0]  regs [8];
    logic [15:0] pc, mar, rd;
    logic [7:0]  ir;

    always_comb begin
        rd = 16'h0;
        if (bus_if.reg_out_en) begin
            case (bus_if.reg_read_sel)
                5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: rd = {8'h0, regs[bus_if.reg_read_sel[2:0]]};
                5'd8:  rd = {regs[0], regs[1]};
                5'd9:  rd = {regs[2], regs[3]};
                5'd10: rd = {regs[4], regs[5]};
                5'd11: rd = {regs[6], regs[7]};
                5'd13: rd = pc;
                default: rd = 16'h0;
            endcase
        end else if (bus_if.mem_out_en) begin
            rd = {8'h0, mem[mar[7:0]]};
        end
        bus_if.data_in = rd[7:0];
        bus_if.opcode  = ir;
    end

    always @(posedge clk) begin
        if (rst) begin
            pc  <= 16'h0;
            mar <= 16'h0;
            ir  <= 8'h00;
            for (int i = 0; i < 8; i++) regs[i] <= gp_init(i);
        end else begin
            if (bus_if.mem_mar_write_en) mar <= rd;
            if (bus_if.ir_write_en) ir <= rd[7:0];
            if (bus_if.reg_write_en) begin
                if (bus_if.reg_write_sel == 5'd13) pc <= rd;
                else if (bus_if.reg_write_sel < 5'd8) regs[bus_if.reg_write_sel[2:0]] <= rd[7:0];
            end
            if (bus_if.reg_write_sel == 5'd13 && bus_if.reg_ext_op != 2'b00)
                pc <= pc + ((bus_if.reg_ext_op == 2'b11) ? 16'd2 : (bus_if.reg_ext_op == 2'b10) ? 16'hFFFF : 16'd1);
        end
    end

    // ---- instruction-level model ----
    int m_acc, m_flags, m_pc;

    function automatic int alu_model(input int op, input int a, input int b, input int cy_in);
        int r, c, ac, cy, ones;
        ac = 0; cy = 0; c = 0;
        if (op <= 1) begin
            c = (op == 1) ? cy_in : 0;
            r = a + b + c;
            cy = (r > 255);
            ac = ((a % 16) + (b % 16) + c) > 15;
            r = r % 256;
        end else if (op == 2 || op == 3 || op == 7) begin
            c = (op == 3) ? cy_in : 0;
            cy = (a < b + c);
            ac = ((a % 16) + 15 - (b % 16) + 1 - c) > 15;
            r = (a - b - c + 256) % 256;
        end else if (op == 4) r = a & b;
        else if (op == 5) r = a ^ b;
        else r = a | b;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
        return (r << 8) | ((r >= 128) ? 128 : 0) | ((r == 0) ? 64 : 0) | (ac ? 16 : 0)
               | ((ones % 2 == 0) ? 4 : 0) | 2 | cy;
    endfunction

    task automatic model_step(output int cyc);
        int op, rv, z;
        op = mem[m_pc % 256];
        z = (m_flags >> 6) & 1;
        if (op == 'h3E) begin
            m_acc = mem[(m_pc + 1) % 256]; m_pc += 2; cyc = 4;
        end else if (op == 'hC6) begin
            rv = alu_model(0, m_acc, mem[(m_pc + 1) % 256], 0);
            m_acc = rv >> 8; m_flags = rv % 256; m_pc += 2; cyc = 5;
        end else if (op == 'hD3) begin
            m_pc += 2; cyc = 3;
        end else if (op >= 'h78 && op <= 'h7D) begin
            m_acc = gp_init(op - 'h78); m_pc += 1; cyc = 3;
        end else if (op >= 'h80 && op <= 'hBF && (op % 8) < 6) begin
            rv = alu_model((op - 'h80) / 8, m_acc, gp_init(op % 8), m_flags % 2);
            m_flags = rv % 256;
            if ((op - 'h80) / 8 != 7) m_acc = rv >> 8;
            m_pc += 1; cyc = 4;
        end else if (op == 'hC3 || (op == 'hCA && z == 1) || (op == 'hC2 && z == 0)) begin
            m_pc = mem[(m_pc + 1) % 256] + 256 * mem[(m_pc + 2) % 256]; cyc = 7;
        end else if (op == 'hCA || op == 'hC2) begin
            m_pc += 3; cyc = 3;
        end else begin
            m_pc += 1; cyc = 3;
        end
    endtask

    // ---- compare process ----
    localparam logic [9:0] T0_CTL = 10'b0001000100;
    localparam logic [9:0] T1_CTL = 10'b0000010010;
    logic [9:0] ctl;
    assign ctl = {bus_if.output_alu, bus_if.alu_out_en, bus_if.alu_flags_out_en, bus_if.reg_out_en,
                  bus_if.reg_write_en, bus_if.mem_out_en, bus_if.mem_write_en, bus_if.mem_mar_write_en,
                  bus_if.ir_write_en, bus_if.hlt};

    logic       boundary = 1'b0, chk_out = 1'b0, chk_inc2 = 1'b0;
    logic [7:0] exp_acc, exp_flags;
    logic [15:0] exp_pc;

    always @(negedge clk) begin
        if (boundary) begin
            check("bnd_ctl", 32'(ctl), 32'(T0_CTL));
            check("bnd_read_sel", 32'(bus_if.reg_read_sel), 32'd13);
            check("bnd_step", 32'(bus_if.step), 32'd0);
            check("bnd_acc", 32'(bus_if.alu_out), 32'(exp_acc));
            check("bnd_flags", 32'(bus_if.flags_out), 32'(exp_flags));
            check("bnd_pc", 32'(pc), 32'(exp_pc));
        end
        if (chk_out) begin
            check("out_strobe", 32'(bus_if.output_alu), 32'd1);
            check("out_value", 32'(bus_if.alu_out), 32'(exp_acc));
        end
        if (chk_inc2) begin
            check("skip_ext_op", 32'(bus_if.reg_ext_op), 32'd3);
            check("skip_write_sel", 32'(bus_if.reg_write_sel), 32'd13);
        end
    end

    task automatic set_boundary();
        exp_acc   = 8'(m_acc);
        exp_flags = 8'(m_flags);
        exp_pc    = 16'(m_pc);
        boundary  = 1'b1;
    endtask

    // ---- program and directed sequence ----
    initial begin
        int cyc, pc0, op;
        logic [7:0] prog [53];
        prog = '{8'h3E, 8'h0F, 8'hC6, 8'h01, 8'hD3, 8'h00, 8'h3E, 8'h80, 8'h90, 8'hCA, 8'h10, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h3E, 8'h05, 8'hB9, 8'hCA, 8'h00, 8'h00, 8'h7A, 8'hA1,
                 8'hAB, 8'hB0, 8'h8A, 8'hC2, 8'h20, 8'h00, 8'h00, 8'h00, 8'h99, 8'hC3, 8'h30, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'hC6, 8'hF1, 8'h01, 8'h00, 8'h76};
        for (int i = 0; i < 256; i++) mem[i] = (i < 53) ? prog[i] : 8'h00;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ctl_t0", 32'(ctl), 32'(T0_CTL));
        check("rst_read_sel", 32'(bus_if.reg_read_sel), 32'd13);
        check("rst_ext_op", 32'(bus_if.reg_ext_op), 32'd0);
        check("rst_acc", 32'(bus_if.alu_out), 32'd0);
        check("rst_flags", 32'(bus_if.flags_out), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd1);
        @(posedge clk); #1;
        check("t1_ctl", 32'(ctl), 32'(T1_CTL));
        check("t1_write_sel", 32'(bus_if.reg_write_sel), 32'd13);
        check("t1_ext_op", 32'(bus_if.reg_ext_op), 32'd1);
        @(posedge clk); #1;
        check("t2_step", 32'(bus_if.step), 32'd2);

        // reset lands in the middle of MVI
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_acc = 0; m_flags = 0; m_pc = 0;
        set_boundary();

        for (int n = 0; n < 40; n++) begin
            pc0 = m_pc;
            op = mem[m_pc % 256];
            if (op == 'h76) break;
            model_step(cyc);
            if (pc0 == 'h09) check("model_jz_taken_cyc", 32'(cyc), 32'd7);
            if (pc0 == 'h13) check("model_jz_skip_cyc", 32'(cyc), 32'd3);
            for (int k = 1; k < cyc; k++) begin
                @(posedge clk); #1;
                boundary = 1'b0;
                chk_out  = (k == 2) && (op == 'hD3);
                chk_inc2 = (k == 2) && (op == 'hCA || op == 'hC2) && (cyc == 3);
            end
            @(posedge clk); #1;
            chk_out = 1'b0; chk_inc2 = 1'b0;
            set_boundary();
            if (pc0 == 'h02) begin
                check("model_adi_acc", 32'(m_acc), 32'h10);
                check("model_adi_flags", 32'(m_flags), 32'h12);
                check("adi_flags", 32'(bus_if.flags_out), 32'h12);
            end
            if (pc0 == 'h08) begin
                check("model_sub_flags", 32'(m_flags), 32'h56);
                check("sub_flags", 32'(bus_if.flags_out), 32'h56);
                check("sub_acc", 32'(bus_if.alu_out), 32'h00);
            end
            if (pc0 == 'h12) begin
                check("model_cmp_flags", 32'(m_flags), 32'h87);
                check("cmp_flags", 32'(bus_if.flags_out), 32'h87);
                check("cmp_acc", 32'(bus_if.alu_out), 32'h05);
            end
        end

        // HLT: T0, T1, then frozen at T2
        @(posedge clk); #1 boundary = 1'b0;
        @(posedge clk); #1;
        check("hlt_ctl", 32'(ctl), 32'd1);
        check("hlt_clk_out", 32'(clk_out), 32'd0);
        check("hlt_step", 32'(bus_if.step), 32'd2);
        repeat (4) begin
            @(posedge clk); #1;
            check("halted_step", 32'(bus_if.step), 32'd2);
            check("halted_hlt", 32'(bus_if.hlt), 32'd1);
            check("halted_clk_out", 32'(clk_out), 32'd0);
            check("halted_acc", 32'(bus_if.alu_out), 32'(m_acc));
            check("halted_flags", 32'(bus_if.flags_out), 32'(m_flags));
        end

        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_acc = 0; m_flags = 0; m_pc = 0;
        set_boundary();
        check("unhalt_hlt", 32'(bus_if.hlt), 32'd0);
        check("unhalt_clk_out", 32'(clk_out), 32'd1);
        @(posedge clk); #1 boundary = 1'b0;
        check("unhalt_t1_ctl", 32'(ctl), 32'(T1_CTL));
        @(posedge clk); #1;
        check("unhalt_step", 32'(bus_if.step), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
